multicycle_control: RTL and testbench
=====================================

# multicycle_control

Multi-cycle sequencing controller for the RV32I subset core (lw, sw, R-type, I-type ALU, beq, jal). It replaces single-cycle decode with a Moore FSM that steps one shared ALU, one unified instruction/data memory port and the register file through fetch, decode, execute, memory and writeback. Memory accesses use a ready handshake so wait states are supported. The block sits between the instruction register and the multi-cycle datapath muxes and enables.

## Interface
- No parameters.
- clk  in  1  core clock
- rst_n  in  1  synchronous active-low reset
- op  in  7  instruction[6:0], from the instruction register
- funct3  in  3  instruction[14:12]
- funct7b5  in  1  instruction[30]
- zero  in  1  ALU zero flag
- mem_ready  in  1  memory completes the current access this cycle
- mem_req  out  1  memory access request
- memwrite  out  1  store strobe
- irwrite  out  1  load the instruction register (and oldPC)
- pcwrite  out  1  PC load enable
- adrsrc  out  1  memory address select: 0 = PC, 1 = ALU result register
- regwrite  out  1  register-file write enable
- alusrca  out  2  ALU A select: 00 = PC, 01 = oldPC, 10 = rs1
- alusrcb  out  2  ALU B select: 00 = rs2, 01 = imm, 10 = constant 4
- resultsrc  out  2  result select: 00 = ALU result register, 01 = memory data, 10 = ALU output
- immsrc  out  2  immediate format: 00 = I, 01 = S, 10 = B, 11 = J
- aluctrl  out  3  ALU operation: 000 = add, 001 = sub, 010 = and, 011 = or, 101 = slt
- illegal_instr  out  1  sticky unsupported-opcode flag (see Configuration)

## Operation
- States: FETCH, DECODE, MEMADR, MEMREAD, MEMWB, MEMWRITE, EXECR, EXECI, ALUWB, BEQ, JAL, plus TRAP when the macro is defined.
- FETCH: mem_req = 1, adrsrc = 0, alusrca = 00, alusrcb = 10, aluop add, resultsrc = 10. When mem_ready = 1: irwrite = 1, pcwrite = 1, next state DECODE. Otherwise stay in FETCH.
- DECODE: alusrca = 01, alusrcb = 01, aluop add (branch or jump target). Next state by op:
  - 0000011 or 0100011 → MEMADR
  - 0110011 → EXECR
  - 0010011 → EXECI
  - 1100011 → BEQ
  - 1101111 → JAL
  - any other → TRAP or FETCH (see Configuration)
- MEMADR: alusrca = 10, alusrcb = 01, add. Next state MEMREAD for a load, MEMWRITE for a store.
- MEMREAD: mem_req = 1, adrsrc = 1. Next state MEMWB on mem_ready. MEMWB: resultsrc = 01, regwrite = 1, then FETCH.
- MEMWRITE: mem_req = 1, adrsrc = 1, memwrite = 1, held until mem_ready. Next state FETCH on mem_ready.
- EXECR: alusrca = 10, alusrcb = 00, aluop funct. EXECI: alusrca = 10, alusrcb = 01, aluop funct. Both go to ALUWB.
- ALUWB: resultsrc = 00, regwrite = 1, then FETCH.
- BEQ: alusrca = 10, alusrcb = 00, sub, resultsrc = 00, pcwrite = zero, then FETCH.
- JAL: alusrca = 01, alusrcb = 10, add, resultsrc = 00, pcwrite = 1, then ALUWB (writes oldPC + 4).
- immsrc is combinational on op: 0100011 → 01, 1100011 → 10, 1101111 → 11, all others → 00.
- aluctrl decode:
  - aluop add → 000; aluop sub → 001.
  - aluop funct, by funct3: 000 → 001 if op[5] & funct7b5, else 000; 010 → 101; 110 → 011; 111 → 010; others → 000.
- All outputs not listed for a state are 0.

## Timing
- Outputs are Moore-decoded from the state register. pcwrite, irwrite and the FETCH/MEMREAD/MEMWRITE exits are additionally gated by mem_ready, and the BEQ pcwrite by zero.
- Cycles per instruction with mem_ready tied high: lw 5, sw 4, R-type 4, I-type 4, jal 4, beq 3. Each wait cycle adds 1.
- Reset: with rst_n low at a clock edge, state ← FETCH and illegal_instr ← 0. While rst_n is low, mem_req, memwrite, irwrite, pcwrite and regwrite are forced to 0; mux selects take their FETCH values.
- Reset mid-access (e.g. in MEMWRITE while waiting) abandons the access; no memwrite is issued in the following cycle.
- mem_ready is ignored in non-memory states. op is sampled only in DECODE and MEMADR, and the instruction register holds it stable.

## Configuration
- MC_ILLEGAL_TRAP_EN defined: an unsupported op in DECODE goes to TRAP. In TRAP, illegal_instr = 1 and all enables are 0; TRAP exits only via reset.
- Not defined: an unsupported op executes as a NOP (DECODE → FETCH) and illegal_instr is tied to 0.

## Structure
- Package riscv_mc_pkg holds:
  - the state enum;
  - opcode constants (OP_LOAD, OP_STORE, OP_RTYPE, OP_ITYPE, OP_BRANCH, OP_JAL);
  - aluctrl, immsrc, alusrca/alusrcb and resultsrc encodings;
  - the aluop enum (add, sub, funct).
- One sub-module: alu_decoder, taking aluop, funct3, op[5] and funct7b5 and producing aluctrl.

## Test plan
- add (op 0110011, funct3 000, funct7b5 0), mem_ready = 1: 4 cycles; aluctrl 000 in EXECR; regwrite for exactly 1 cycle in ALUWB. With funct7b5 = 1: aluctrl 001.
- lw with mem_ready low for 2 cycles in MEMREAD: 7 cycles total; mem_req held with adrsrc = 1; regwrite with resultsrc 01 one cycle after mem_ready.
- beq, zero = 1 → pcwrite pulses in BEQ; zero = 0 → no pcwrite in BEQ. Both return to FETCH after 3 cycles.
- sw, then rst_n low while waiting in MEMWRITE → next cycle memwrite = 0, mem_req = 0; after release, state FETCH.
- op 1111111 with the macro defined → illegal_instr = 1 from the TRAP cycle onward, no enables, cleared only by rst_n. Without the macro → FETCH on the next cycle and illegal_instr stays 0.
- jal: pcwrite in FETCH and JAL; regwrite in ALUWB; immsrc 11 throughout.

Source files
------------

// File: rtl/riscv_mc_pkg.sv
// Shared encodings for the multi-cycle RV32I sequencing controller.
// TRAP state exists only when MC_ILLEGAL_TRAP_EN is defined.
package riscv_mc_pkg;

  typedef enum logic [3:0] {
    S_FETCH,
    S_DECODE,
    S_MEMADR,
    S_MEMREAD,
    S_MEMWB,
    S_MEMWRITE,
    S_EXECR,
    S_EXECI,
    S_ALUWB,
    S_BEQ,
    S_JAL
`ifdef MC_ILLEGAL_TRAP_EN
    ,S_TRAP
`endif
  } state_t;

  typedef enum logic [1:0] {
    ALUOP_ADD,
    ALUOP_SUB,
    ALUOP_FUNCT
  } aluop_t;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_RTYPE  = 7'b0110011;
  localparam logic [6:0] OP_ITYPE  = 7'b0010011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_OR  = 3'b011;
  localparam logic [2:0] ALU_SLT = 3'b101;

  localparam logic [1:0] IMM_I = 2'b00;
  localparam logic [1:0] IMM_S = 2'b01;
  localparam logic [1:0] IMM_B = 2'b10;
  localparam logic [1:0] IMM_J = 2'b11;

  localparam logic [1:0] SRCA_PC    = 2'b00;
  localparam logic [1:0] SRCA_OLDPC = 2'b01;
  localparam logic [1:0] SRCA_RS1   = 2'b10;

  localparam logic [1:0] SRCB_RS2  = 2'b00;
  localparam logic [1:0] SRCB_IMM  = 2'b01;
  localparam logic [1:0] SRCB_FOUR = 2'b10;

  localparam logic [1:0] RES_ALUOUT = 2'b00;
  localparam logic [1:0] RES_MEM    = 2'b01;
  localparam logic [1:0] RES_ALU    = 2'b10;

  function automatic logic [1:0] imm_sel(input logic [6:0] op);
    logic [1:0] s;
    s = IMM_I;
    unique case (1'b1)
      op == OP_STORE:  s = IMM_S;
      op == OP_BRANCH: s = IMM_B;
      op == OP_JAL:    s = IMM_J;
      default:         s = IMM_I;
    endcase
    return s;
  endfunction

endpackage

// File: rtl/multicycle_control_alu_decoder.sv
// ALU operation decode from the sequencer's aluop and the funct fields.
// op5 distinguishes R-type sub from I-type addi.
module alu_decoder
  import riscv_mc_pkg::*;
(
  input  aluop_t     aluop,
  input  logic [2:0] funct3,
  input  logic       op5,
  input  logic       funct7b5,
  output logic [2:0] aluctrl
);

  always_comb begin
    aluctrl = ALU_ADD;
    unique case (aluop)
      ALUOP_SUB: aluctrl = ALU_SUB;
      ALUOP_FUNCT: begin
        unique case (funct3)
          3'b000:  aluctrl = (op5 & funct7b5) ? ALU_SUB : ALU_ADD;
          3'b010:  aluctrl = ALU_SLT;
          3'b110:  aluctrl = ALU_OR;
          3'b111:  aluctrl = ALU_AND;
          default: aluctrl = ALU_ADD;
        endcase
      end
      default: aluctrl = ALU_ADD;
    endcase
  end

endmodule

// File: rtl/multicycle_control.sv
// Moore sequencer for the multi-cycle RV32I datapath with memory wait states.
// MC_ILLEGAL_TRAP_EN: unsupported opcodes lock into TRAP instead of acting as NOP.
module multicycle_control
  import riscv_mc_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic [6:0] op,
  input  logic [2:0] funct3,
  input  logic       funct7b5,
  input  logic       zero,
  input  logic       mem_ready,
  output logic       mem_req,
  output logic       memwrite,
  output logic       irwrite,
  output logic       pcwrite,
  output logic       adrsrc,
  output logic       regwrite,
  output logic [1:0] alusrca,
  output logic [1:0] alusrcb,
  output logic [1:0] resultsrc,
  output logic [1:0] immsrc,
  output logic [2:0] aluctrl,
  output logic       illegal_instr
);

  state_t state;
  state_t state_n;
  aluop_t aluop;

  always_ff @(posedge clk) begin
    if (!rst_n) state <= S_FETCH;
    else        state <= state_n;
  end

  always_comb begin
    state_n = state;
    unique case (state)
      S_FETCH:  if (mem_ready) state_n = S_DECODE;
      S_DECODE: begin
        unique case (1'b1)
          (op == OP_LOAD) || (op == OP_STORE):
                           state_n = S_MEMADR;
          op == OP_RTYPE:  state_n = S_EXECR;
          op == OP_ITYPE:  state_n = S_EXECI;
          op == OP_BRANCH: state_n = S_BEQ;
          op == OP_JAL:    state_n = S_JAL;
`ifdef MC_ILLEGAL_TRAP_EN
          default:         state_n = S_TRAP;
`else
          default:         state_n = S_FETCH;
`endif
        endcase
      end
      S_MEMADR:   state_n = (op == OP_STORE) ? S_MEMWRITE : S_MEMREAD;
      S_MEMREAD:  if (mem_ready) state_n = S_MEMWB;
      S_MEMWB:    state_n = S_FETCH;
      S_MEMWRITE: if (mem_ready) state_n = S_FETCH;
      S_EXECR:    state_n = S_ALUWB;
      S_EXECI:    state_n = S_ALUWB;
      S_ALUWB:    state_n = S_FETCH;
      S_BEQ:      state_n = S_FETCH;
      S_JAL:      state_n = S_ALUWB;
`ifdef MC_ILLEGAL_TRAP_EN
      S_TRAP:     state_n = S_TRAP;
`endif
      default:    state_n = S_FETCH;
    endcase
  end

  always_comb begin
    mem_req   = 1'b0;
    memwrite  = 1'b0;
    irwrite   = 1'b0;
    pcwrite   = 1'b0;
    adrsrc    = 1'b0;
    regwrite  = 1'b0;
    alusrca   = SRCA_PC;
    alusrcb   = SRCB_RS2;
    resultsrc = RES_ALUOUT;
    aluop     = ALUOP_ADD;
    unique case (state)
      S_FETCH: begin
        mem_req   = 1'b1;
        alusrcb   = SRCB_FOUR;
        resultsrc = RES_ALU;
        irwrite   = mem_ready;
        pcwrite   = mem_ready;
      end
      S_DECODE: begin
        alusrca = SRCA_OLDPC;
        alusrcb = SRCB_IMM;
      end
      S_MEMADR: begin
        alusrca = SRCA_RS1;
        alusrcb = SRCB_IMM;
      end
      S_MEMREAD: begin
        mem_req = 1'b1;
        adrsrc  = 1'b1;
      end
      S_MEMWB: begin
        resultsrc = RES_MEM;
        regwrite  = 1'b1;
      end
      S_MEMWRITE: begin
        mem_req  = 1'b1;
        adrsrc   = 1'b1;
        memwrite = 1'b1;
      end
      S_EXECR: begin
        alusrca = SRCA_RS1;
        aluop   = ALUOP_FUNCT;
      end
      S_EXECI: begin
        alusrca = SRCA_RS1;
        alusrcb = SRCB_IMM;
        aluop   = ALUOP_FUNCT;
      end
      S_ALUWB: regwrite = 1'b1;
      S_BEQ: begin
        alusrca = SRCA_RS1;
        aluop   = ALUOP_SUB;
        pcwrite = zero;
      end
      S_JAL: begin
        alusrca = SRCA_OLDPC;
        alusrcb = SRCB_FOUR;
        pcwrite = 1'b1;
      end
      default: ;
    endcase
    // Reset abandons any access in flight and parks muxes on fetch
    if (!rst_n) begin
      mem_req   = 1'b0;
      memwrite  = 1'b0;
      irwrite   = 1'b0;
      pcwrite   = 1'b0;
      regwrite  = 1'b0;
      adrsrc    = 1'b0;
      alusrca   = SRCA_PC;
      alusrcb   = SRCB_FOUR;
      resultsrc = RES_ALU;
      aluop     = ALUOP_ADD;
    end
  end

  assign immsrc = imm_sel(op);

`ifdef MC_ILLEGAL_TRAP_EN
  assign illegal_instr = (state == S_TRAP);
`else
  assign illegal_instr = 1'b0;
`endif

  alu_decoder u_alu_decoder (
    .aluop    (aluop),
    .funct3   (funct3),
    .op5      (op[5]),
    .funct7b5 (funct7b5),
    .aluctrl  (aluctrl)
  );

endmodule

// File: tb/tb_multicycle_control.sv
// Randomised check of the multi-cycle controller against a per-instruction
// micro-step model, plus directed instructions with literal expectations.
module tb_multicycle_control;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [6:0] op;
  logic [2:0] funct3;
  logic       funct7b5;
  logic       zero;
  logic       mem_ready;
  logic       mem_req;
  logic       memwrite;
  logic       irwrite;
  logic       pcwrite;
  logic       adrsrc;
  logic       regwrite;
  logic [1:0] alusrca;
  logic [1:0] alusrcb;
  logic [1:0] resultsrc;
  logic [1:0] immsrc;
  logic [2:0] aluctrl;
  logic       illegal_instr;

  always #5 clk = ~clk;

  multicycle_control dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .op            (op),
    .funct3        (funct3),
    .funct7b5      (funct7b5),
    .zero          (zero),
    .mem_ready     (mem_ready),
    .mem_req       (mem_req),
    .memwrite      (memwrite),
    .irwrite       (irwrite),
    .pcwrite       (pcwrite),
    .adrsrc        (adrsrc),
    .regwrite      (regwrite),
    .alusrca       (alusrca),
    .alusrcb       (alusrcb),
    .resultsrc     (resultsrc),
    .immsrc        (immsrc),
    .aluctrl       (aluctrl),
    .illegal_instr (illegal_instr)
  );

  localparam logic [6:0] LD  = 7'b0000011;
  localparam logic [6:0] ST  = 7'b0100011;
  localparam logic [6:0] RT  = 7'b0110011;
  localparam logic [6:0] IT  = 7'b0010011;
  localparam logic [6:0] BR  = 7'b1100011;
  localparam logic [6:0] JL  = 7'b1101111;
  localparam logic [6:0] BAD = 7'b1111111;

  typedef struct packed {
    logic       mem_req;
    logic       memwrite;
    logic       irwrite;
    logic       pcwrite;
    logic       adrsrc;
    logic       regwrite;
    logic [1:0] alusrca;
    logic [1:0] alusrcb;
    logic [1:0] resultsrc;
    logic [1:0] immsrc;
    logic [2:0] aluctrl;
    logic       illegal;
  } vec_t;

  typedef struct {
    string name;
    vec_t  v;
    bit    mem;
    bit    fetch;
    bit    beq;
    bit    trap;
  } step_t;

  step_t q[$];
  int    n_cmp = 0;
  int    n_bad = 0;
  vec_t  obs;
  bit    nxt_valid = 0;
  logic [6:0] nxt_op;
  logic [2:0] nxt_f3;
  logic       nxt_f7;

  function automatic logic [1:0] m_imm(input logic [6:0] o);
    if (o == ST) return 2'b01;
    if (o == BR) return 2'b10;
    if (o == JL) return 2'b11;
    return 2'b00;
  endfunction

  function automatic logic [2:0] m_alu(input logic [2:0] f3, input logic sub);
    case (f3)
      3'b000:  return sub ? 3'b001 : 3'b000;
      3'b010:  return 3'b101;
      3'b110:  return 3'b011;
      3'b111:  return 3'b010;
      default: return 3'b000;
    endcase
  endfunction

  function automatic step_t mk(input string n, input logic [1:0] a,
                               input logic [1:0] b, input logic [1:0] r,
                               input logic [2:0] c);
    step_t s;
    s.name        = n;
    s.v           = '0;
    s.v.alusrca   = a;
    s.v.alusrcb   = b;
    s.v.resultsrc = r;
    s.v.aluctrl   = c;
    s.mem         = 0;
    s.fetch       = 0;
    s.beq         = 0;
    s.trap        = 0;
    return s;
  endfunction

  // Micro-step list for one whole instruction, fetch included
  task automatic push_instr(input logic [6:0] o, input logic [2:0] f3,
                            input logic f7);
    step_t s;
    s = mk("fetch", 2'd0, 2'd2, 2'd2, 3'd0);
    s.v.mem_req = 1; s.fetch = 1; s.mem = 1;
    q.push_back(s);
    s = mk("decode", 2'd1, 2'd1, 2'd0, 3'd0);
    q.push_back(s);
    if (o == LD || o == ST) begin
      s = mk("memadr", 2'd2, 2'd1, 2'd0, 3'd0);
      q.push_back(s);
      if (o == LD) begin
        s = mk("memread", 2'd0, 2'd0, 2'd0, 3'd0);
        s.v.mem_req = 1; s.v.adrsrc = 1; s.mem = 1;
        q.push_back(s);
        s = mk("memwb", 2'd0, 2'd0, 2'd1, 3'd0);
        s.v.regwrite = 1;
        q.push_back(s);
      end else begin
        s = mk("memwrite", 2'd0, 2'd0, 2'd0, 3'd0);
        s.v.mem_req = 1; s.v.adrsrc = 1; s.v.memwrite = 1; s.mem = 1;
        q.push_back(s);
      end
    end else if (o == RT || o == IT || o == JL) begin
      if (o == RT)      s = mk("execr", 2'd2, 2'd0, 2'd0, m_alu(f3, f7));
      else if (o == IT) s = mk("execi", 2'd2, 2'd1, 2'd0, m_alu(f3, 1'b0));
      else begin
        s = mk("jal", 2'd1, 2'd2, 2'd0, 3'd0);
        s.v.pcwrite = 1;
      end
      q.push_back(s);
      s = mk("aluwb", 2'd0, 2'd0, 2'd0, 3'd0);
      s.v.regwrite = 1;
      q.push_back(s);
    end else if (o == BR) begin
      s = mk("beq", 2'd2, 2'd0, 2'd0, 3'd1);
      s.beq = 1;
      q.push_back(s);
    end else begin
`ifdef MC_ILLEGAL_TRAP_EN
      s = mk("trap", 2'd0, 2'd0, 2'd0, 3'd0);
      s.v.illegal = 1; s.trap = 1;
      q.push_back(s);
`endif
    end
  endtask

  function automatic vec_t expected();
    vec_t e;
    e = q[0].v;
    if (q[0].fetch) begin
      e.irwrite = mem_ready;
      e.pcwrite = mem_ready;
    end
    if (q[0].beq) e.pcwrite = zero;
    e.immsrc = m_imm(op);
    if (!rst_n) begin
      e.mem_req = 0; e.memwrite = 0; e.irwrite = 0;
      e.pcwrite = 0; e.regwrite = 0; e.adrsrc = 0;
      e.alusrca = 2'b00; e.alusrcb = 2'b10;
      e.resultsrc = 2'b10; e.aluctrl = 3'b000;
    end
    return e;
  endfunction

  task automatic pick();
    int r;
    if (nxt_valid) begin
      op = nxt_op; funct3 = nxt_f3; funct7b5 = nxt_f7;
      nxt_valid = 0;
    end else begin
      r = $urandom_range(0, 13);
      funct3   = 3'($urandom_range(0, 7));
      funct7b5 = 1'($urandom_range(0, 1));
      case (r)
        0, 1:    op = LD;
        2, 3:    op = ST;
        4, 5, 6: op = RT;
        7, 8, 9: op = IT;
        10, 11:  op = BR;
        12:      op = JL;
        default: op = ($urandom_range(0, 1) == 0) ? BAD : 7'b0110111;
      endcase
    end
    push_instr(op, funct3, funct7b5);
  endtask

  // One clock: drive at negedge, compare 1ns later, advance model
  task automatic cycle(input logic rdy, input logic z, input logic rn);
    vec_t e;
    @(negedge clk);
    if (q.size() == 0) pick();
    mem_ready = rdy;
    zero      = z;
    rst_n     = rn;
    #1;
    obs.mem_req   = mem_req;
    obs.memwrite  = memwrite;
    obs.irwrite   = irwrite;
    obs.pcwrite   = pcwrite;
    obs.adrsrc    = adrsrc;
    obs.regwrite  = regwrite;
    obs.alusrca   = alusrca;
    obs.alusrcb   = alusrcb;
    obs.resultsrc = resultsrc;
    obs.immsrc    = immsrc;
    obs.aluctrl   = aluctrl;
    obs.illegal   = illegal_instr;
    e = expected();
    n_cmp++;
    if (obs !== e) begin
      n_bad++;
      $display("FAIL step %s rst_n=%b: got %h want %h", q[0].name, rn, obs, e);
    end
    if (!rn) q.delete();
    else if (q[0].trap) ;
    else if (q[0].mem && !rdy) ;
    else void'(q.pop_front());
  endtask

  task automatic chk(input string nm, input int got, input int want);
    n_cmp++;
    if (got != want) begin
      n_bad++;
      $display("FAIL %s: got %0d want %0d", nm, got, want);
    end
  endtask

  task automatic drain();
    int k;
    k = 0;
    while (q.size() != 0 && k < 40) begin
      if (q[0].trap) cycle(1'b1, 1'b0, 1'b0);
      else cycle(1'b1, 1'($urandom_range(0, 1)), 1'b1);
      k++;
    end
    chk("drain_bound", q.size(), 0);
  endtask

  task automatic run_dir(input string nm, input logic [6:0] o,
                         input logic [2:0] f3, input logic f7,
                         input int wait_at, input int nwait, input logic z,
                         input int e_cyc, input int e_rw, input int e_pw,
                         input int e_mw, input int probe,
                         input int e_ctrl, input int e_imm);
    int k, w, rw, pw, mw;
    logic rdy;
    k = 0; w = 0; rw = 0; pw = 0; mw = 0;
    nxt_valid = 1; nxt_op = o; nxt_f3 = f3; nxt_f7 = f7;
    do begin
      rdy = (k >= wait_at && w < nwait) ? 1'b0 : 1'b1;
      if (!rdy) w++;
      cycle(rdy, z, 1'b1);
      rw += int'(obs.regwrite);
      pw += int'(obs.pcwrite);
      mw += int'(obs.memwrite);
      if (k == probe) begin
        chk({nm, "_aluctrl"}, int'(obs.aluctrl), e_ctrl);
        chk({nm, "_immsrc"}, int'(obs.immsrc), e_imm);
      end
      k++;
    end while (q.size() != 0 && k < 40);
    chk({nm, "_cycles"}, k, e_cyc);
    chk({nm, "_regwrite"}, rw, e_rw);
    chk({nm, "_pcwrite"}, pw, e_pw);
    chk({nm, "_memwrite"}, mw, e_mw);
  endtask

  initial begin
    logic rn;
    rst_n = 1'b0; mem_ready = 1'b0; zero = 1'b0;
    op = 7'd0; funct3 = 3'd0; funct7b5 = 1'b0;

    cycle(1'b1, 1'b0, 1'b0);
    chk("rst_mem_req", int'(obs.mem_req), 0);
    chk("rst_pcwrite", int'(obs.pcwrite), 0);
    chk("rst_alusrcb", int'(obs.alusrcb), 2);
    chk("rst_resultsrc", int'(obs.resultsrc), 2);
    chk("rst_illegal", int'(obs.illegal), 0);
    cycle(1'b1, 1'b0, 1'b0);

    run_dir("add",   RT, 3'b000, 1'b0, 99, 0, 1'b0, 4, 1, 1, 0, 2, 0, 0);
    run_dir("sub",   RT, 3'b000, 1'b1, 99, 0, 1'b0, 4, 1, 1, 0, 2, 1, 0);
    run_dir("and",   RT, 3'b111, 1'b0, 99, 0, 1'b0, 4, 1, 1, 0, 2, 2, 0);
    run_dir("slti",  IT, 3'b010, 1'b0, 99, 0, 1'b0, 4, 1, 1, 0, 2, 5, 0);
    run_dir("ori",   IT, 3'b110, 1'b1, 99, 0, 1'b0, 4, 1, 1, 0, 2, 3, 0);
    run_dir("addi7", IT, 3'b000, 1'b1, 99, 0, 1'b0, 4, 1, 1, 0, 2, 0, 0);
    run_dir("lw",    LD, 3'b010, 1'b0, 99, 0, 1'b0, 5, 1, 1, 0, 4, 0, 0);
    run_dir("lw_w2", LD, 3'b010, 1'b0, 3, 2, 1'b0, 7, 1, 1, 0, 3, 0, 0);
    run_dir("fetch_w1", RT, 3'b000, 1'b0, 0, 1, 1'b0, 5, 1, 1, 0, 1, 0, 0);
    run_dir("sw",    ST, 3'b010, 1'b0, 99, 0, 1'b0, 4, 0, 1, 1, 3, 0, 1);
    run_dir("sw_w1", ST, 3'b010, 1'b0, 3, 1, 1'b0, 5, 0, 1, 2, 3, 0, 1);
    run_dir("beq_t", BR, 3'b000, 1'b0, 99, 0, 1'b1, 3, 0, 2, 0, 2, 1, 2);
    run_dir("beq_n", BR, 3'b000, 1'b0, 99, 0, 1'b0, 3, 0, 1, 0, 2, 1, 2);
    run_dir("jal",   JL, 3'b000, 1'b0, 99, 0, 1'b0, 4, 1, 2, 0, 3, 0, 3);

    // Store abandoned by reset while waiting on memory
    nxt_valid = 1; nxt_op = ST; nxt_f3 = 3'b010; nxt_f7 = 1'b0;
    cycle(1'b1, 1'b0, 1'b1);
    cycle(1'b1, 1'b0, 1'b1);
    cycle(1'b1, 1'b0, 1'b1);
    cycle(1'b0, 1'b0, 1'b1);
    chk("sw_wait_memwrite", int'(obs.memwrite), 1);
    cycle(1'b0, 1'b0, 1'b0);
    chk("sw_rst_memwrite", int'(obs.memwrite), 0);
    chk("sw_rst_mem_req", int'(obs.mem_req), 0);
    nxt_valid = 1; nxt_op = RT; nxt_f3 = 3'b000; nxt_f7 = 1'b0;
    cycle(1'b1, 1'b0, 1'b1);
    chk("post_rst_fetch_req", int'(obs.mem_req), 1);
    chk("post_rst_adrsrc", int'(obs.adrsrc), 0);
    chk("post_rst_memwrite", int'(obs.memwrite), 0);
    chk("post_rst_irwrite", int'(obs.irwrite), 1);
    drain();

    // Unsupported opcode
    nxt_valid = 1; nxt_op = BAD; nxt_f3 = 3'b000; nxt_f7 = 1'b0;
    cycle(1'b1, 1'b0, 1'b1);
    cycle(1'b1, 1'b0, 1'b1);
    chk("bad_decode_illegal", int'(obs.illegal), 0);
`ifdef MC_ILLEGAL_TRAP_EN
    for (int i = 0; i < 3; i++) begin
      cycle(1'b1, 1'b1, 1'b1);
      chk("trap_illegal", int'(obs.illegal), 1);
      chk("trap_enables", int'({obs.mem_req, obs.memwrite, obs.irwrite,
                                obs.pcwrite, obs.regwrite}), 0);
    end
    cycle(1'b1, 1'b0, 1'b0);
    nxt_valid = 1; nxt_op = RT; nxt_f3 = 3'b000; nxt_f7 = 1'b0;
    cycle(1'b1, 1'b0, 1'b1);
    chk("trap_cleared", int'(obs.illegal), 0);
    chk("trap_exit_fetch", int'(obs.mem_req), 1);
`else
    nxt_valid = 1; nxt_op = RT; nxt_f3 = 3'b000; nxt_f7 = 1'b0;
    cycle(1'b1, 1'b0, 1'b1);
    chk("nop_fetch", int'(obs.mem_req), 1);
    chk("nop_illegal", int'(obs.illegal), 0);
`endif
    drain();

    for (int i = 0; i < 3000; i++) begin
      rn = ($urandom_range(0, 99) < 2) ? 1'b0 : 1'b1;
      if (q.size() != 0 && q[0].trap && $urandom_range(0, 3) == 0) rn = 1'b0;
      cycle(($urandom_range(0, 9) < 7) ? 1'b1 : 1'b0,
            1'($urandom_range(0, 1)), rn);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
